// File: rtl/cpu_tstate_seq_pkg.sv
// Shared types for the 6502C T-state sequencer: sequencer states, interrupt source
// codes and helpers that derive the T-counter and source-code widths.
package cpu_tstate_seq_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_INT   = 2'd2
  } tstate_e;

  localparam int unsigned SRC_NONE = 0;
  localparam int unsigned SRC_RST  = 1;
  localparam int unsigned SRC_NMI  = 2;
  localparam int unsigned SRC_IRQ0 = 3;

  function automatic int unsigned tseq_tw(input int unsigned max_t);
    return $clog2(max_t + 1);
  endfunction

  function automatic int unsigned tseq_sw(input int unsigned num_irq);
    return $clog2(num_irq + 3);
  endfunction

endpackage

// File: rtl/cpu_tstate_seq_int_arb.sv
// Interrupt arbiter: NMI request capture, fixed-priority encoder and pending-source register.
// TSEQ_NMI_EDGE_EN selects an edge-latched NMI; otherwise NMI is a level request.
module tseq_int_arb
  import cpu_tstate_seq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned SW      = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sample_i,
  input  logic               clear_i,
  input  logic               nmi_i,
  input  logic               nmi_ack_i,
  input  logic               i_flag_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [SW-1:0]      pend_src_o
);

  logic          nmi_req;
  logic [SW-1:0] win;
  logic [SW-1:0] pend_q, pend_d;

`ifdef TSEQ_NMI_EDGE_EN
  logic nmi_prev_q, nmi_lat_q, nmi_lat_d;

  // A new edge coinciding with the ack must survive the clear.
  always_comb nmi_lat_d = (nmi_i & ~nmi_prev_q) | (nmi_lat_q & ~nmi_ack_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nmi_prev_q <= 1'b0;
      nmi_lat_q  <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_i;
      nmi_lat_q  <= nmi_lat_d;
    end
  end

  assign nmi_req = nmi_lat_q;
`else
  logic unused_nmi_ack;
  assign unused_nmi_ack = nmi_ack_i;
  assign nmi_req        = nmi_i;
`endif

  // Scan from the highest index down so the lowest-index request wins.
  always_comb begin
    win = '0;
    for (int unsigned k = NUM_IRQ; k > 0; k--) begin
      if (irq_i[k-1] && !i_flag_i) win = SW'(SRC_IRQ0 + k - 1);
    end
    if (nmi_req) win = SW'(SRC_NMI);
  end

  always_comb begin
    pend_d = pend_q;
    if (clear_i)       pend_d = '0;
    else if (sample_i) pend_d = win;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign pend_src_o = pend_q;

endmodule

// File: rtl/cpu_tstate_seq.sv
// T-state sequencer and interrupt sequencer for the 6502C control path.
// Optional TSEQ_NMI_EDGE_EN: edge-latched NMI (default: level-sensitive NMI).
module cpu_tstate_seq
  import cpu_tstate_seq_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned MAX_T      = 8,
  parameter int unsigned INT_CYCLES = 7,
  localparam int unsigned TW = tseq_tw(MAX_T),
  localparam int unsigned SW = tseq_sw(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [TW-1:0]      cyc_len,
  input  logic               early_end,
  input  logic               i_flag,
  input  logic               nmi,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [MAX_T-1:0]   t_onehot,
  output logic               sync,
  output logic               t1_next,
  output logic               force_brk,
  output logic               int_active,
  output logic [SW-1:0]      int_src,
  output logic               nmi_ack,
  output logic [NUM_IRQ-1:0] irq_ack
);

  tstate_e            state_q, state_d;
  logic [TW-1:0]      t_q, t_d, len_q, len_d;
  logic [SW-1:0]      src_q, src_d, pend_src;
  logic               nmi_ack_q, nmi_ack_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic               sample, clear, int_done;

  tseq_int_arb #(
    .NUM_IRQ (NUM_IRQ),
    .SW      (SW)
  ) u_arb (
    .clk_i      (clk),
    .rst_ni     (rst),
    .sample_i   (sample),
    .clear_i    (clear),
    .nmi_i      (nmi),
    .nmi_ack_i  (nmi_ack_q),
    .i_flag_i   (i_flag),
    .irq_i      (irq),
    .pend_src_o (pend_src)
  );

  always_comb begin
    state_d   = state_q;
    t_d       = t_q + TW'(1);
    len_d     = len_q;
    src_d     = src_q;
    sync      = 1'b0;
    t1_next   = 1'b0;
    force_brk = 1'b0;
    int_done  = 1'b0;
    sample    = 1'b0;
    clear     = 1'b0;
    case (state_q)
      S_FETCH: begin
        sync      = 1'b1;
        force_brk = (pend_src != '0);
        t_d       = TW'(2);
        if (cyc_len < TW'(2))          len_d = TW'(2);
        else if (cyc_len > TW'(MAX_T)) len_d = TW'(MAX_T);
        else                           len_d = cyc_len;
        if (force_brk) begin
          state_d = S_INT;
          src_d   = pend_src;
          clear   = rdy;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        t1_next = (t_q == len_q) || (early_end && (t_q >= TW'(2)));
        if (t1_next) begin
          state_d = S_FETCH;
          t_d     = TW'(1);
          sample  = rdy;
        end
      end
      S_INT: begin
        int_done = (t_q == TW'(INT_CYCLES));
        t1_next  = int_done;
        if (int_done) begin
          state_d = S_FETCH;
          t_d     = TW'(1);
          src_d   = '0;
        end
      end
      default: begin
        state_d = S_FETCH;
        t_d     = TW'(1);
      end
    endcase
  end

  // Ack for the finishing source; RST decodes to no ack.
  always_comb begin
    nmi_ack_d = int_done && (src_q == SW'(SRC_NMI));
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      irq_ack_d[k] = int_done && (src_q == SW'(SRC_IRQ0 + k));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INT;
      t_q       <= TW'(2);
      len_q     <= TW'(2);
      src_q     <= SW'(SRC_RST);
      nmi_ack_q <= 1'b0;
      irq_ack_q <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      t_q       <= t_d;
      len_q     <= len_d;
      src_q     <= src_d;
      nmi_ack_q <= nmi_ack_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < MAX_T; k++) begin
      t_onehot[k] = (t_q == TW'(k + 1));
    end
  end

  assign int_active = (state_q == S_INT);
  assign int_src    = src_q;
  assign nmi_ack    = nmi_ack_q;
  assign irq_ack    = irq_ack_q;

endmodule
